// File: rtl/mesh_router_xy.sv
// mesh_router_xy: 5-port XY mesh router node with per-input FIFOs and round-robin output arbitration.
// Define MESH_ROUTER_DROP_CNT_EN to add the saturating drop_cnt output.
module mesh_router_xy #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ROWS  = 2,
  parameter int unsigned COLS  = 3,
  parameter int unsigned X_ID  = 0,
  parameter int unsigned Y_ID  = 0,
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5*WIDTH-1:0] in_data,
  input  logic [4:0]         in_valid,
  output logic [4:0]         in_ready,
  output logic [5*WIDTH-1:0] out_data,
  output logic [4:0]         out_valid,
  input  logic [4:0]         out_ready
`ifdef MESH_ROUTER_DROP_CNT_EN
  ,
  output logic [15:0]        drop_cnt
`endif
);
  localparam int unsigned NP = 5;
  localparam int unsigned XW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned YW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0]   mem_q [NP][DEPTH];
  logic [WIDTH-1:0]   mem_d [NP][DEPTH];
  logic [AW-1:0]      wr_q [NP];
  logic [AW-1:0]      wr_d [NP];
  logic [AW-1:0]      rd_q [NP];
  logic [AW-1:0]      rd_d [NP];
  logic [CW-1:0]      cnt_q [NP];
  logic [CW-1:0]      cnt_d [NP];
  logic [2:0]         last_q [NP];
  logic [2:0]         last_d [NP];
  logic [5*WIDTH-1:0] out_data_q, out_data_d;
  logic [4:0]         out_valid_q, out_valid_d;

  logic [WIDTH-1:0]   head [NP];
  logic [2:0]         route [NP];
  logic [2:0]         gnt_src [NP];
  logic [4:0]         req, drop, push, pop, granted, free, gnt_vld;
  logic [3:0]         cand_sum;
  logic [XW-1:0]      dx;
  logic [YW-1:0]      dy;

  // Head decode: XY route, out-of-mesh heads are discarded instead of requesting.
  always_comb begin
    dx = '0;
    dy = '0;
    for (int i = 0; i < NP; i++) begin
      head[i]     = mem_q[i][rd_q[i]];
      dx          = head[i][XW-1:0];
      dy          = head[i][XW+YW-1:XW];
      in_ready[i] = (cnt_q[i] != CW'(DEPTH)) && !reset;
      push[i]     = in_valid[i] && in_ready[i];
      drop[i]     = (cnt_q[i] != '0) && ((32'(dx) >= COLS) || (32'(dy) >= ROWS));
      req[i]      = (cnt_q[i] != '0) && !drop[i];
      if (32'(dx) > X_ID)      route[i] = 3'd3;
      else if (32'(dx) < X_ID) route[i] = 3'd4;
      else if (32'(dy) > Y_ID) route[i] = 3'd1;
      else if (32'(dy) < Y_ID) route[i] = 3'd2;
      else                     route[i] = 3'd0;
    end
  end

  // Per-output round robin, search starting one past the last winner.
  always_comb begin
    gnt_vld  = '0;
    granted  = '0;
    free     = '0;
    cand_sum = '0;
    for (int o = 0; o < NP; o++) begin
      gnt_src[o] = '0;
      last_d[o]  = last_q[o];
      free[o]    = !out_valid_q[o] || out_ready[o];
      for (int k = 1; k <= NP; k++) begin
        cand_sum = 4'(last_q[o]) + 4'(k);
        if (cand_sum >= 4'(NP)) cand_sum = cand_sum - 4'(NP);
        if (free[o] && !gnt_vld[o] && req[cand_sum[2:0]] && (route[cand_sum[2:0]] == 3'(o))) begin
          gnt_vld[o] = 1'b1;
          gnt_src[o] = cand_sum[2:0];
        end
      end
      if (gnt_vld[o]) begin
        last_d[o]           = gnt_src[o];
        granted[gnt_src[o]] = 1'b1;
      end
    end
  end

  assign pop = drop | granted;

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < NP; i++) begin
      wr_d[i]  = wr_q[i];
      rd_d[i]  = rd_q[i];
      cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      if (push[i]) begin
        mem_d[i][wr_q[i]] = in_data[i*WIDTH +: WIDTH];
        wr_d[i]           = wr_q[i] + AW'(1);
      end
      if (pop[i]) rd_d[i] = rd_q[i] + AW'(1);
    end
  end

  // Output register: holds until accepted, reloads on the accepting edge.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q & ~out_ready;
    for (int o = 0; o < NP; o++) begin
      if (gnt_vld[o]) begin
        out_valid_d[o]                = 1'b1;
        out_data_d[o*WIDTH +: WIDTH]  = head[gnt_src[o]];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NP; i++) begin
        wr_q[i]   <= '0;
        rd_q[i]   <= '0;
        cnt_q[i]  <= '0;
        last_q[i] <= 3'd4;
      end
      out_data_q  <= '0;
      out_valid_q <= '0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        wr_q[i]   <= wr_d[i];
        rd_q[i]   <= rd_d[i];
        cnt_q[i]  <= cnt_d[i];
        last_q[i] <= last_d[i];
      end
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

`ifdef MESH_ROUTER_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [2:0]  ndrop;
  logic [16:0] drop_sum;

  always_comb begin
    ndrop = '0;
    for (int i = 0; i < NP; i++) ndrop = ndrop + 3'(drop[i]);
    drop_sum   = 17'(drop_cnt_q) + 17'(ndrop);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_mesh_router_xy.sv
// Directed bench for mesh_router_xy at node (1,0) of a 3x2 mesh: routing table,
// round-robin order, backpressure and mid-flight reset.
module tb_mesh_router_xy;
  logic        clk;
  logic        reset;
  logic [79:0] in_data;
  logic [4:0]  in_valid;
  logic [4:0]  in_ready;
  logic [79:0] out_data;
  logic [4:0]  out_valid;
  logic [4:0]  out_ready;
`ifdef MESH_ROUTER_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  mesh_router_xy #(
    .WIDTH(16), .ROWS(2), .COLS(3), .X_ID(1), .Y_ID(0), .DEPTH(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef MESH_ROUTER_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [15:0] flit;
    logic [4:0]  exp_valid;
    int          exp_port;
    int          exp_drops;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push one flit per port in mask on the same edge; expect PE output in the given order.
  task automatic rr_round(input logic [4:0] mask, input logic [14:0] order, input int n);
    logic [2:0] p;
    out_ready = '1;
    for (int i = 0; i < 5; i++) in_data[i*16 +: 16] = {4'(i + 1), 12'h001};
    in_valid = mask;
    step();
    in_valid = '0;
    chk("rr_idle", 32'(out_valid), 32'h0);
    for (int j = 0; j < n; j++) begin
      step();
      p = order[j*3 +: 3];
      chk("rr_valid", 32'(out_valid), 32'h1);
      chk("rr_data", 32'(out_data[15:0]), 32'({4'(int'(p) + 1), 12'h001}));
    end
    step();
    chk("rr_drain", 32'(out_valid), 32'h0);
  endtask

  initial begin
    // port, flit, expected out_valid, expected port, cumulative drops
    vecs[0]  = '{0, 16'h0002, 5'b01000, 3, 0};
    vecs[1]  = '{4, 16'h0005, 5'b00010, 1, 0};
    vecs[2]  = '{4, 16'h0001, 5'b00001, 0, 0};
    vecs[3]  = '{0, 16'h0003, 5'b00000, 0, 1};
    vecs[4]  = '{3, 16'hAB00, 5'b10000, 4, 1};
    vecs[5]  = '{1, 16'h1234, 5'b10000, 4, 1};
    vecs[6]  = '{2, 16'h5676, 5'b01000, 3, 1};
    vecs[7]  = '{0, 16'h00F5, 5'b00010, 1, 1};
    vecs[8]  = '{1, 16'h0107, 5'b00000, 0, 2};
    vecs[9]  = '{3, 16'hBEE1, 5'b00001, 0, 2};
    vecs[10] = '{0, 16'h0001, 5'b00001, 0, 2};

    reset     = 1'b1;
    in_data   = '0;
    in_valid  = '0;
    out_ready = '1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data[31:0], 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'h1F);
`ifdef MESH_ROUTER_DROP_CNT_EN
    chk("rel_drop_cnt", 32'(drop_cnt), 32'h0);
`endif

    // Single-flit routing table
    foreach (vecs[v]) begin
      in_data = '0;
      in_data[vecs[v].port*16 +: 16] = vecs[v].flit;
      in_valid[vecs[v].port] = 1'b1;
      chk("vec_in_ready", 32'(in_ready), 32'h1F);
      step();
      in_valid = '0;
      chk("vec_latency", 32'(out_valid), 32'h0);
      step();
      chk("vec_out_valid", 32'(out_valid), 32'(vecs[v].exp_valid));
      if (vecs[v].exp_valid != '0)
        chk("vec_out_data", 32'(out_data[vecs[v].exp_port*16 +: 16]), 32'(vecs[v].flit));
      step();
      chk("vec_drain", 32'(out_valid), 32'h0);
`ifdef MESH_ROUTER_DROP_CNT_EN
      chk("vec_drop_cnt", 32'(drop_cnt), 32'(vecs[v].exp_drops));
`endif
    end

    // Round robin from a fresh pointer, then from pointer states left by earlier rounds
    reset = 1'b1;
    step();
    reset = 1'b0;
    rr_round(5'b11110, {3'd0, 3'd4, 3'd3, 3'd2, 3'd1}, 4);
    rr_round(5'b11111, {3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 5);
    rr_round(5'b00110, {3'd0, 3'd0, 3'd0, 3'd2, 3'd1}, 2);
    rr_round(5'b01111, {3'd0, 3'd2, 3'd1, 3'd0, 3'd3}, 4);
    rr_round(5'b11111, {3'd2, 3'd1, 3'd0, 3'd4, 3'd3}, 5);

    // East blocked: four FIFO entries plus the output register fill, sixth offer refused
    out_ready = 5'b10111;
    in_data   = '0;
    for (int i = 0; i < 5; i++) begin
      in_data[15:0] = {8'(i + 1), 8'h02};
      in_valid[0]   = 1'b1;
      chk("bp_accept", 32'(in_ready[0]), 32'h1);
      step();
    end
    in_data[15:0] = 16'h0602;
    chk("bp_full", 32'(in_ready[0]), 32'h0);
    step();
    chk("bp_full_hold", 32'(in_ready[0]), 32'h0);
    chk("bp_out_valid", 32'(out_valid), 32'h08);
    chk("bp_out_data", 32'(out_data[48 +: 16]), 32'h0102);
    in_valid  = '0;
    out_ready = '1;
    for (int i = 1; i < 5; i++) begin
      step();
      chk("bp_drain_valid", 32'(out_valid), 32'h08);
      chk("bp_drain_data", 32'(out_data[48 +: 16]), 32'({8'(i + 1), 8'h02}));
    end
    step();
    chk("bp_empty", 32'(out_valid), 32'h0);

    // Reset with three flits buffered toward a blocked east port
    out_ready = 5'b10111;
    for (int i = 0; i < 3; i++) begin
      in_data[15:0] = {8'(i + 7), 8'h02};
      in_valid[0]   = 1'b1;
      step();
    end
    in_valid = '0;
    chk("mid_loaded", 32'(out_valid), 32'h08);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_out_valid", 32'(out_valid), 32'h0);
    chk("mid_out_data", 32'(out_data[48 +: 16]), 32'h0);
    chk("mid_in_ready", 32'(in_ready), 32'h0);
    step();
    step();
    reset     = 1'b0;
    out_ready = '1;
    #1;
    chk("mid_rel_ready", 32'(in_ready), 32'h1F);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_no_stale", 32'(out_valid), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
